// File: rtl/vip_ram_if.sv
// VIP record command/response bundle between a client menu (master) and the
// record store (slave).
interface vip_ram_if;
  // Commands are level-held by the client. The slave accepts a command only
  // on a transition from 00 to nonzero. It answers with a one-cycle r_ack_o
  // pulse. The client must return to 00 before it issues the next command.
  logic [1:0]  w_wr_ram_vip_i;
  logic [1:0]  w_vip_i;
  logic [4:0]  w_vip_movie_number_i;
  logic [31:0] w_vip_cost_i;
  logic [31:0] w_vip_save_i;
  logic [19:0] w_vip_password_i;
  logic [2:0]  w_vip_day_i;

  logic [1:0]  r_vip_o;
  logic [4:0]  r_vip_movie_number_o;
  logic [31:0] r_vip_cost_o;
  logic [31:0] r_vip_save_o;
  logic [19:0] r_vip_password_o;
  logic [2:0]  r_vip_day_o;
  logic [4:0]  r_vip_off_o;
  logic        r_ack_o;
  logic        r_err_o;

  modport master (
    output w_wr_ram_vip_i, w_vip_i, w_vip_movie_number_i, w_vip_cost_i,
           w_vip_save_i, w_vip_password_i, w_vip_day_i,
    input  r_vip_o, r_vip_movie_number_o, r_vip_cost_o, r_vip_save_o,
           r_vip_password_o, r_vip_day_o, r_vip_off_o, r_ack_o, r_err_o
  );

  modport slave (
    input  w_wr_ram_vip_i, w_vip_i, w_vip_movie_number_i, w_vip_cost_i,
           w_vip_save_i, w_vip_password_i, w_vip_day_i,
    output r_vip_o, r_vip_movie_number_o, r_vip_cost_o, r_vip_save_o,
           r_vip_password_o, r_vip_day_o, r_vip_off_o, r_ack_o, r_err_o
  );
endinterface

// File: rtl/vip_ram_ctrl.sv
// VIP record store: executes create/update/read commands from the record
// interface, returns slot contents plus the discount, and ages active days.
module vip_ram_ctrl #(
  parameter int unsigned NUM_VIP = 4,
  parameter logic [4:0]  OFF_MAX = 5'd20
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     day_tick,
  vip_ram_if.slave bus,
  output logic     dbg_state
);

  localparam logic [1:0] CMD_IDLE   = 2'b00;
  localparam logic [1:0] CMD_CREATE = 2'b01;
  localparam logic [1:0] CMD_UPDATE = 2'b10;
  localparam logic [1:0] CMD_READ   = 2'b11;

  typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [1:0]  prev_cmd;
  logic        fire;
  logic [1:0]  cmd, idx;

  logic        slot_valid [NUM_VIP];
  logic [4:0]  movie_q    [NUM_VIP];
  logic [31:0] cost_q     [NUM_VIP];
  logic [31:0] save_q     [NUM_VIP];
  logic [19:0] pw_q       [NUM_VIP];
  logic [2:0]  day_q      [NUM_VIP];

  logic        cur_valid;
  logic        do_write;
  logic        res_err;
  logic [4:0]  res_movie;
  logic [31:0] res_cost, res_save;
  logic [19:0] res_pw;
  logic [2:0]  res_day;

  assign cmd       = bus.w_wr_ram_vip_i;
  assign idx       = bus.w_vip_i;
  assign dbg_state = state;

  function automatic logic [4:0] off_of(input logic [2:0] d, input logic [4:0] m);
    if (d == 3'd0)       return 5'd0;
    else if (m < 5'd5)   return 5'd5;
    else if (m < 5'd10)  return 5'd10;
    else if (m < 5'd20)  return 5'd15;
    else                 return OFF_MAX;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      prev_cmd <= CMD_IDLE;
    end else begin
      state    <= state_nxt;
      prev_cmd <= cmd;
    end
  end

  // Edges seen while in EXEC are dropped; prev_cmd still tracks the level.
  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    case (state)
      S_IDLE: begin
        if (prev_cmd == CMD_IDLE && cmd != CMD_IDLE) begin
          fire      = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Response contents are the slot as it looks after the command; invalid
  // slots are never written, so their stored fields are zero.
  always_comb begin
    cur_valid = slot_valid[idx];
    do_write  = 1'b0;
    res_err   = 1'b0;
    res_movie = cur_valid ? movie_q[idx] : 5'd0;
    res_cost  = cur_valid ? cost_q[idx]  : 32'd0;
    res_save  = cur_valid ? save_q[idx]  : 32'd0;
    res_pw    = cur_valid ? pw_q[idx]    : 20'd0;
    res_day   = cur_valid ? day_q[idx]   : 3'd0;
    case (cmd)
      CMD_CREATE: begin
        if (cur_valid) begin
          res_err = 1'b1;
        end else begin
          do_write  = fire;
          res_movie = 5'd0;
          res_cost  = 32'd0;
          res_save  = 32'd0;
          res_pw    = bus.w_vip_password_i;
          res_day   = 3'd0;
        end
      end
      CMD_UPDATE: begin
        if (!cur_valid) begin
          res_err = 1'b1;
        end else begin
          do_write  = fire;
          res_movie = bus.w_vip_movie_number_i;
          res_cost  = bus.w_vip_cost_i;
          res_save  = bus.w_vip_save_i;
          res_pw    = bus.w_vip_password_i;
          res_day   = bus.w_vip_day_i;
        end
      end
      CMD_READ: res_err = !cur_valid;
      default:  res_err = 1'b0;
    endcase
  end

  // A write to a slot overrides that slot's aging in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VIP; i++) begin
        slot_valid[i] <= 1'b0;
        movie_q[i]    <= 5'd0;
        cost_q[i]     <= 32'd0;
        save_q[i]     <= 32'd0;
        pw_q[i]       <= 20'd0;
        day_q[i]      <= 3'd0;
      end
    end else begin
      for (int i = 0; i < NUM_VIP; i++) begin
        if (do_write && idx == 2'(i)) begin
          slot_valid[i] <= 1'b1;
          movie_q[i]    <= res_movie;
          cost_q[i]     <= res_cost;
          save_q[i]     <= res_save;
          pw_q[i]       <= res_pw;
          day_q[i]      <= res_day;
        end else if (day_tick && slot_valid[i] && day_q[i] != 3'd0) begin
          day_q[i] <= day_q[i] - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.r_ack_o              <= 1'b0;
      bus.r_err_o              <= 1'b0;
      bus.r_vip_o              <= 2'd0;
      bus.r_vip_movie_number_o <= 5'd0;
      bus.r_vip_cost_o         <= 32'd0;
      bus.r_vip_save_o         <= 32'd0;
      bus.r_vip_password_o     <= 20'd0;
      bus.r_vip_day_o          <= 3'd0;
      bus.r_vip_off_o          <= 5'd0;
    end else begin
      bus.r_ack_o <= fire;
      if (fire) begin
        bus.r_err_o              <= res_err;
        bus.r_vip_o              <= idx;
        bus.r_vip_movie_number_o <= res_movie;
        bus.r_vip_cost_o         <= res_cost;
        bus.r_vip_save_o         <= res_save;
        bus.r_vip_password_o     <= res_pw;
        bus.r_vip_day_o          <= res_day;
        bus.r_vip_off_o          <= off_of(res_day, res_movie);
      end
    end
  end

endmodule

// File: tb/tb_vip_ram_ctrl.sv
// Directed and randomized checks of vip_ram_ctrl against a slot-level record model.
module tb_vip_ram_ctrl;
  localparam logic [4:0] OFF_MAX = 5'd20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic day_tick = 1'b0;
  logic dbg_state;

  vip_ram_if bus();

  vip_ram_ctrl #(.NUM_VIP(4), .OFF_MAX(OFF_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .day_tick(day_tick), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  bit          m_valid [4];
  logic [4:0]  m_movie [4];
  logic [31:0] m_cost  [4];
  logic [31:0] m_save  [4];
  logic [19:0] m_pw    [4];
  logic [2:0]  m_day   [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] exp_off(input logic [2:0] d, input logic [4:0] m);
    if (d == 3'd0) return 5'd0;
    if (m >= 5'd20) return OFF_MAX;
    if (m >= 5'd10) return 5'd15;
    if (m >= 5'd5) return 5'd10;
    return 5'd5;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0; m_movie[i] = '0; m_cost[i] = '0;
      m_save[i] = '0; m_pw[i] = '0; m_day[i] = '0;
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] e_vip, input logic [4:0] e_mv,
                            input logic [31:0] e_co, input logic [31:0] e_sv,
                            input logic [19:0] e_pw, input logic [2:0] e_dy,
                            input logic [4:0] e_off, input logic e_err, input logic e_ack);
    chk({tag, ":ack"},   bus.r_ack_o, e_ack);
    chk({tag, ":err"},   bus.r_err_o, e_err);
    chk({tag, ":vip"},   bus.r_vip_o, e_vip);
    chk({tag, ":movie"}, bus.r_vip_movie_number_o, e_mv);
    chk({tag, ":cost"},  bus.r_vip_cost_o, e_co);
    chk({tag, ":save"},  bus.r_vip_save_o, e_sv);
    chk({tag, ":pw"},    bus.r_vip_password_o, e_pw);
    chk({tag, ":day"},   bus.r_vip_day_o, e_dy);
    chk({tag, ":off"},   bus.r_vip_off_o, e_off);
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] c, input logic [1:0] v,
                        input logic [4:0] mv, input logic [31:0] co, input logic [31:0] sv,
                        input logic [19:0] pw, input logic [2:0] dy, input logic tk);
    int          wr;
    logic        e_err;
    logic [4:0]  e_mv;
    logic [31:0] e_co, e_sv;
    logic [19:0] e_pw;
    logic [2:0]  e_dy;
    wr = -1;
    case (c)
      2'd1: begin
        e_err = m_valid[v];
        if (!m_valid[v]) begin
          m_valid[v] = 1'b1; m_pw[v] = pw; m_movie[v] = '0;
          m_cost[v] = '0; m_save[v] = '0; m_day[v] = '0; wr = int'(v);
        end
      end
      2'd2: begin
        e_err = !m_valid[v];
        if (m_valid[v]) begin
          m_movie[v] = mv; m_cost[v] = co; m_save[v] = sv;
          m_pw[v] = pw; m_day[v] = dy; wr = int'(v);
        end
      end
      default: e_err = !m_valid[v];
    endcase
    e_mv = m_valid[v] ? m_movie[v] : 5'd0;
    e_co = m_valid[v] ? m_cost[v]  : 32'd0;
    e_sv = m_valid[v] ? m_save[v]  : 32'd0;
    e_pw = m_valid[v] ? m_pw[v]    : 20'd0;
    e_dy = m_valid[v] ? m_day[v]   : 3'd0;
    if (tk) begin
      for (int i = 0; i < 4; i++)
        if (i != wr && m_valid[i] && m_day[i] != 3'd0) m_day[i] = m_day[i] - 3'd1;
    end
    @(negedge clk);
    bus.w_wr_ram_vip_i = c; bus.w_vip_i = v; bus.w_vip_movie_number_i = mv;
    bus.w_vip_cost_i = co; bus.w_vip_save_i = sv; bus.w_vip_password_i = pw;
    bus.w_vip_day_i = dy; day_tick = tk;
    @(posedge clk); #1;
    day_tick = 1'b0;
    check_outs(tag, v, e_mv, e_co, e_sv, e_pw, e_dy, exp_off(e_dy, e_mv), e_err, 1'b1);
    @(negedge clk);
    bus.w_wr_ram_vip_i = 2'b00;
    @(posedge clk); #1;
    chk({tag, ":ack_drop"}, bus.r_ack_o, 1'b0);
  endtask

  task automatic tick_pulse();
    @(negedge clk);
    day_tick = 1'b1;
    @(posedge clk); #1;
    day_tick = 1'b0;
    for (int i = 0; i < 4; i++)
      if (m_valid[i] && m_day[i] != 3'd0) m_day[i] = m_day[i] - 3'd1;
  endtask

  initial begin
    int acks;
    model_reset();
    bus.w_wr_ram_vip_i = '0; bus.w_vip_i = '0; bus.w_vip_movie_number_i = '0;
    bus.w_vip_cost_i = '0; bus.w_vip_save_i = '0; bus.w_vip_password_i = '0;
    bus.w_vip_day_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 2'd0, 5'd0, 32'd0, 32'd0, 20'd0, 3'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    do_cmd("rd_empty2", 2'd3, 2'd2, 5'd0, 32'd0, 32'd0, 20'd0, 3'd0, 1'b0);
    do_cmd("create1", 2'd1, 2'd1, 5'd9, 32'd5, 32'd6, 20'h12345, 3'd4, 1'b0);
    do_cmd("rd1_new", 2'd3, 2'd1, 5'd0, 32'd0, 32'd0, 20'd0, 3'd0, 1'b0);
    do_cmd("create1_dup", 2'd1, 2'd1, 5'd0, 32'd0, 32'd0, 20'hABCDE, 3'd0, 1'b0);
    do_cmd("rd1_dup", 2'd3, 2'd1, 5'd0, 32'd0, 32'd0, 20'd0, 3'd0, 1'b0);
    do_cmd("upd1_m7", 2'd2, 2'd1, 5'd7, 32'd300, 32'd30, 20'h12345, 3'd3, 1'b0);
    do_cmd("rd1_m7", 2'd3, 2'd1, 5'd0, 32'd0, 32'd0, 20'd0, 3'd0, 1'b0);
    do_cmd("upd1_m25", 2'd2, 2'd1, 5'd25, 32'd300, 32'd30, 20'h12345, 3'd3, 1'b0);
    do_cmd("upd_invalid3", 2'd2, 2'd3, 5'd1, 32'd1, 32'd1, 20'h1, 3'd1, 1'b0);

    repeat (4) tick_pulse();
    chk("tick_no_refresh_day", bus.r_vip_day_o, 3'd0);
    chk("tick_no_refresh_vip", bus.r_vip_o, 2'd3);
    do_cmd("rd1_aged", 2'd3, 2'd1, 5'd0, 32'd0, 32'd0, 20'd0, 3'd0, 1'b0);

    do_cmd("create0", 2'd1, 2'd0, 5'd0, 32'd0, 32'd0, 20'h0BEEF, 3'd0, 1'b0);
    do_cmd("upd0_d2", 2'd2, 2'd0, 5'd12, 32'd77, 32'd7, 20'h0BEEF, 3'd2, 1'b0);
    do_cmd("upd1_tick", 2'd2, 2'd1, 5'd3, 32'd400, 32'd40, 20'h12345, 3'd5, 1'b1);
    do_cmd("rd1_tickwin", 2'd3, 2'd1, 5'd0, 32'd0, 32'd0, 20'd0, 3'd0, 1'b0);
    do_cmd("rd0_aged", 2'd3, 2'd0, 5'd0, 32'd0, 32'd0, 20'd0, 3'd0, 1'b0);
    do_cmd("rd0_tick", 2'd3, 2'd0, 5'd0, 32'd0, 32'd0, 20'd0, 3'd0, 1'b1);

    // Held read must execute once; a direct 11 -> 10 change must not execute.
    @(negedge clk);
    bus.w_wr_ram_vip_i = 2'd3; bus.w_vip_i = 2'd1;
    acks = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.r_ack_o) acks++;
    end
    chk("hold_one_ack", acks, 1);
    chk("hold_rd_day", bus.r_vip_day_o, m_day[1]);
    @(negedge clk);
    bus.w_wr_ram_vip_i = 2'd2; bus.w_vip_movie_number_i = 5'd31; bus.w_vip_day_i = 3'd7;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.r_ack_o) acks++;
    end
    chk("switch_no_ack", acks, 0);
    @(negedge clk);
    bus.w_wr_ram_vip_i = 2'd0;
    @(posedge clk);
    do_cmd("rd1_after_switch", 2'd3, 2'd1, 5'd0, 32'd0, 32'd0, 20'd0, 3'd0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) tick_pulse();
      do_cmd("rand", 2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
             5'($urandom_range(0, 31)), $urandom, $urandom, 20'($urandom),
             3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
    end

    // Reset during the execute cycle of an update.
    @(negedge clk);
    bus.w_wr_ram_vip_i = 2'd2; bus.w_vip_i = 2'd1; bus.w_vip_day_i = 3'd6;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_exec_ack", bus.r_ack_o, 1'b0);
    chk("rst_exec_err", bus.r_err_o, 1'b0);
    bus.w_wr_ram_vip_i = 2'd0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd("rd1_after_rst", 2'd3, 2'd1, 5'd0, 32'd0, 32'd0, 20'd0, 3'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
